// File: rtl/membus_master.sv
// membus_master: processor-side membus cycle controller for single read, write and RMW cycles.
// Optional NXM abort in REQ is enabled by defining MEMBUS_NXM_TIMEOUT_EN.
module membus_master #(
  parameter int WR_HOLD    = 4,
  parameter int WR_RS_LEN  = 2,
  parameter int NXM_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_rd,
  input  logic         req_wr,
  input  logic [18:35] req_addr,
  input  logic         req_fmc,
  input  logic [0:35]  wdata,
  input  logic         wr_go,
  output logic [0:35]  rdata,
  output logic         resp_valid,
  output logic         resp_nxm,
  output logic         membus_rq_cyc,
  output logic         membus_rd_rq,
  output logic         membus_wr_rq,
  output logic [21:35] membus_ma,
  output logic [18:21] membus_sel,
  output logic         membus_fmc_select,
  output logic [0:35]  membus_mb_out,
  output logic         membus_wr_rs,
  input  logic         membus_addr_ack,
  input  logic         membus_rd_rs,
  input  logic [0:35]  membus_mb_in
);

  localparam int CMAX0 = (WR_HOLD > WR_RS_LEN) ? WR_HOLD : WR_RS_LEN;
  localparam int CMAX  = (CMAX0 > NXM_CYCLES) ? CMAX0 : NXM_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, RD_WAIT, RMW_WAIT, WR_DATA, WR_RS, DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            rd_q, wr_q, nxm_q;
  logic [0:35]     wdata_q, rdata_q, mb_out_q;
  logic            req_ready_q, resp_valid_q, resp_nxm_q;
  logic            rq_cyc_q, rd_rq_q, wr_rq_q, wr_rs_q, fmc_q;
  logic [21:35]    ma_q;
  logic [18:21]    sel_q;
  logic            ack_prev_q, rs_prev_q;
  logic            ack_edge, rs_edge, nxm_expire;

  // Memory strobes are wide asynchronous pulses; only their leading edge counts.
  assign ack_edge = membus_addr_ack & ~ack_prev_q;
  assign rs_edge  = membus_rd_rs & ~rs_prev_q;

`ifdef MEMBUS_NXM_TIMEOUT_EN
  assign nxm_expire = (cnt_q == CW'(NXM_CYCLES - 1));
`else
  assign nxm_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      nxm_q        <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mb_out_q     <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_nxm_q   <= 1'b0;
      rq_cyc_q     <= 1'b0;
      rd_rq_q      <= 1'b0;
      wr_rq_q      <= 1'b0;
      wr_rs_q      <= 1'b0;
      fmc_q        <= 1'b0;
      ma_q         <= '0;
      sel_q        <= '0;
      ack_prev_q   <= 1'b0;
      rs_prev_q    <= 1'b0;
    end else begin
      ack_prev_q   <= membus_addr_ack;
      rs_prev_q    <= membus_rd_rs;
      resp_valid_q <= 1'b0;
      resp_nxm_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q && (req_rd || req_wr)) begin
            req_ready_q <= 1'b0;
            rd_q        <= req_rd;
            wr_q        <= req_wr;
            nxm_q       <= 1'b0;
            wdata_q     <= wdata;
            rdata_q     <= '0;
            rq_cyc_q    <= 1'b1;
            rd_rq_q     <= req_rd;
            wr_rq_q     <= req_wr;
            ma_q        <= req_addr[21:35];
            sel_q       <= req_addr[18:21];
            fmc_q       <= req_fmc;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // addr_ack takes priority over a timeout expiring in the same cycle.
          if (ack_edge) begin
            rq_cyc_q <= 1'b0;
            rd_rq_q  <= 1'b0;
            wr_rq_q  <= 1'b0;
            cnt_q    <= '0;
            if (rd_q) begin
              state_q <= RD_WAIT;
            end else begin
              mb_out_q <= wdata_q;
              state_q  <= WR_DATA;
            end
          end else if (nxm_expire) begin
            rq_cyc_q <= 1'b0;
            rd_rq_q  <= 1'b0;
            wr_rq_q  <= 1'b0;
            nxm_q    <= 1'b1;
            rdata_q  <= '0;
            state_q  <= DONE;
          end
        end
        RD_WAIT: begin
          // Memory drives data as a pulse, so accumulate rather than sample once.
          rdata_q <= rdata_q | membus_mb_in;
          if (rs_edge) begin
            if (wr_q) begin
              resp_valid_q <= 1'b1;
              state_q      <= RMW_WAIT;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RMW_WAIT: begin
          if (wr_go) begin
            wdata_q  <= wdata;
            mb_out_q <= wdata;
            cnt_q    <= '0;
            state_q  <= WR_DATA;
          end
        end
        WR_DATA: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WR_HOLD - 1)) begin
            cnt_q   <= '0;
            wr_rs_q <= 1'b1;
            state_q <= WR_RS;
          end
        end
        WR_RS: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WR_RS_LEN - 1)) begin
            cnt_q    <= '0;
            wr_rs_q  <= 1'b0;
            mb_out_q <= '0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          resp_valid_q <= 1'b1;
          resp_nxm_q   <= nxm_q;
          ma_q         <= '0;
          sel_q        <= '0;
          fmc_q        <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready         = req_ready_q;
  assign rdata             = rdata_q;
  assign resp_valid        = resp_valid_q;
  assign resp_nxm          = resp_nxm_q;
  assign membus_rq_cyc     = rq_cyc_q;
  assign membus_rd_rq      = rd_rq_q;
  assign membus_wr_rq      = wr_rq_q;
  assign membus_ma         = ma_q;
  assign membus_sel        = sel_q;
  assign membus_fmc_select = fmc_q;
  assign membus_mb_out     = mb_out_q;
  assign membus_wr_rs      = wr_rs_q;

endmodule

// File: tb/tb_membus_master.sv
// Scoreboard bench for membus_master: directed requests, a behavioural core-memory model on the bus,
// and a monitor that pops expected responses whenever resp_valid pulses.
`timescale 1ns/1ps
module tb_membus_master;
  localparam int WR_HOLD    = 4;
  localparam int WR_RS_LEN  = 2;
  localparam int NXM_CYCLES = 20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid, req_ready, req_rd, req_wr, req_fmc, wr_go;
  logic [18:35] req_addr;
  logic [0:35]  wdata, rdata, membus_mb_out, membus_mb_in;
  logic         resp_valid, resp_nxm;
  logic         membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select, membus_wr_rs;
  logic [21:35] membus_ma;
  logic [18:21] membus_sel;
  logic         membus_addr_ack, membus_rd_rs;

  membus_master #(.WR_HOLD(WR_HOLD), .WR_RS_LEN(WR_RS_LEN), .NXM_CYCLES(NXM_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_fmc(req_fmc), .wdata(wdata), .wr_go(wr_go),
    .rdata(rdata), .resp_valid(resp_valid), .resp_nxm(resp_nxm),
    .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq), .membus_wr_rq(membus_wr_rq),
    .membus_ma(membus_ma), .membus_sel(membus_sel), .membus_fmc_select(membus_fmc_select),
    .membus_mb_out(membus_mb_out), .membus_wr_rs(membus_wr_rs),
    .membus_addr_ack(membus_addr_ack), .membus_rd_rs(membus_rd_rs), .membus_mb_in(membus_mb_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [0:35] rdata; logic nxm; } resp_t;
  resp_t       exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          resp_cnt = 0, last_resp_cyc = 0, last_rs_cyc = 0;
  logic [0:35] mem [int];
  logic        mem_en = 1'b1;
  int          ack_len = 3;
  logic [0:35] exp_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  function automatic int akey(input logic [18:35] a);
    return int'({a[18:21], a[21:35]});
  endfunction

  // Monitor: every resp_valid pulse consumes one scoreboard entry.
  initial forever begin
    @(negedge clk);
    if (reset_n && resp_valid) begin
      resp_t e;
      resp_cnt++;
      last_resp_cyc = cyc;
      if (exp_q.size() == 0) fail("unexpected_resp");
      else begin
        e = exp_q.pop_front();
        check("resp_rdata", rdata, e.rdata);
        check("resp_nxm", resp_nxm, e.nxm);
      end
    end
  end

  // Core memory model: ack after 2 cycles, read restart 2 cycles after ack drops, capture on wr_rs.
  initial begin
    membus_addr_ack = 1'b0;
    membus_rd_rs    = 1'b0;
    membus_mb_in    = '0;
    forever begin
      @(negedge clk);
      if (reset_n && membus_rq_cyc && mem_en) begin
        int k, ack_cyc, t;
        logic r, w;
        k = int'({membus_sel, membus_ma});
        r = membus_rd_rq;
        w = membus_wr_rq;
        repeat (2) @(negedge clk);
        membus_addr_ack = 1'b1;
        ack_cyc = cyc;
        repeat (ack_len) @(negedge clk);
        membus_addr_ack = 1'b0;
        if (r) begin
          repeat (2) @(negedge clk);
          membus_mb_in = mem.exists(k) ? mem[k] : '0;
          membus_rd_rs = 1'b1;
          last_rs_cyc  = cyc;
          repeat (3) @(negedge clk);
          membus_rd_rs = 1'b0;
          membus_mb_in = '0;
        end
        if (w) begin
          t = 0;
          while (!membus_wr_rs && t < 500) begin
            if (!r) check("wr_mb_hold", membus_mb_out, exp_wdata);
            @(negedge clk);
            t++;
          end
          if (!membus_wr_rs) fail("wr_rs_timeout");
          else begin
            if (!r) check("wr_rs_delay", 64'(cyc - ack_cyc), 64'(WR_HOLD + 1));
            check("wr_mb_out", membus_mb_out, exp_wdata);
            mem[k] = membus_mb_out;
          end
        end
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [18:35] a, input logic [0:35] d,
                       input logic f, output int acc_cyc);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) fail("ready_timeout");
    req_valid = 1'b1; req_rd = r; req_wr = w; req_addr = a; wdata = d; req_fmc = f;
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    check("rq_cyc", membus_rq_cyc, 1);
    check("rd_rq", membus_rd_rq, r);
    check("wr_rq", membus_wr_rq, w);
    check("ma", membus_ma, a[21:35]);
    check("sel", membus_sel, a[18:21]);
    check("fmc", membus_fmc_select, f);
  endtask

  task automatic wait_resp(input int target, input string name);
    int t;
    t = 0;
    while (resp_cnt < target && t < 300) begin @(negedge clk); t++; end
    if (resp_cnt < target) fail({name, "_resp_timeout"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nexp, t;
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_fmc = 1'b0; wr_go = 1'b0;
    req_addr = '0; wdata = '0;
    nexp = 0;
    mem[akey(18'o012345)] = 36'o123456701234;
    mem[akey(18'o000200)] = 36'o5;

    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_bus", {membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs, resp_valid, resp_nxm}, 0);
    check("rst_data", {rdata, membus_mb_out}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // Plain read
    exp_q.push_back('{rdata: 36'o123456701234, nxm: 1'b0});
    nexp++;
    issue(1'b1, 1'b0, 18'o012345, 36'o0, 1'b0, acc);
    wait_resp(nexp, "read");
    check("rd_resp_latency", 64'(last_resp_cyc - last_rs_cyc), 64'd2);
    if (cyc == last_resp_cyc) @(negedge clk);
    check("rd_ready_after", req_ready, 1);
    check("rd_mb_out_idle", membus_mb_out, 0);

    // Write then read back
    exp_wdata = 36'o777777000000;
    exp_q.push_back('{rdata: 36'o0, nxm: 1'b0});
    nexp++;
    issue(1'b0, 1'b1, 18'o000100, 36'o777777000000, 1'b1, acc);
    wait_resp(nexp, "write");
    exp_q.push_back('{rdata: 36'o777777000000, nxm: 1'b0});
    nexp++;
    issue(1'b1, 1'b0, 18'o000100, 36'o0, 1'b0, acc);
    wait_resp(nexp, "readback");

    // Read-modify-write: 5 -> 6
    exp_q.push_back('{rdata: 36'o5, nxm: 1'b0});
    exp_q.push_back('{rdata: 36'o5, nxm: 1'b0});
    nexp++;
    issue(1'b1, 1'b1, 18'o000200, 36'o0, 1'b0, acc);
    wait_resp(nexp, "rmw_read");
    repeat (5) begin
      @(negedge clk);
      check("rmw_wait_bus", {membus_rq_cyc, membus_rd_rq, membus_wr_rq, req_ready}, 0);
    end
    exp_wdata = 36'o6;
    wdata = 36'o6;
    wr_go = 1'b1;
    @(negedge clk);
    wr_go = 1'b0;
    nexp++;
    wait_resp(nexp, "rmw_write");
    exp_q.push_back('{rdata: 36'o6, nxm: 1'b0});
    nexp++;
    issue(1'b1, 1'b0, 18'o000200, 36'o0, 1'b0, acc);
    wait_resp(nexp, "rmw_readback");

    // addr_ack held for 10 cycles: one advance only
    ack_len = 10;
    exp_q.push_back('{rdata: 36'o123456701234, nxm: 1'b0});
    nexp++;
    issue(1'b1, 1'b0, 18'o012345, 36'o0, 1'b0, acc);
    wait_resp(nexp, "long_ack");
    repeat (12) @(negedge clk);
    check("long_ack_single_resp", 64'(resp_cnt), 64'(nexp));
    check("long_ack_idle", {req_ready, membus_rq_cyc}, 2'b10);
    ack_len = 3;

    // Reset asserted mid WR_RS
    exp_wdata = 36'o1;
    issue(1'b0, 1'b1, 18'o000300, 36'o1, 1'b1, acc);
    t = 0;
    while (!membus_wr_rs && t < 100) begin @(negedge clk); t++; end
    if (!membus_wr_rs) fail("reset_test_wr_rs");
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_bus", {membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs, membus_fmc_select,
                            req_ready, resp_valid}, 0);
    check("async_rst_mb_out", membus_mb_out, 0);
    check("async_rst_addr", {membus_ma, membus_sel}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back('{rdata: 36'o123456701234, nxm: 1'b0});
    nexp++;
    issue(1'b1, 1'b0, 18'o012345, 36'o0, 1'b0, acc);
    wait_resp(nexp, "post_reset_read");

`ifdef MEMBUS_NXM_TIMEOUT_EN
    // No memory answers: abort after NXM_CYCLES in REQ
    mem_en = 1'b0;
    exp_q.push_back('{rdata: 36'o0, nxm: 1'b1});
    nexp++;
    issue(1'b1, 1'b0, 18'o012345, 36'o0, 1'b1, acc);
    wait_resp(nexp, "nxm");
    check("nxm_resp_cycle", 64'(last_resp_cyc - acc), 64'(NXM_CYCLES + 2));
    check("nxm_bus_idle", {membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs, membus_fmc_select}, 0);
    check("nxm_addr_idle", {membus_ma, membus_sel, membus_mb_out}, 0);
    mem_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
